serial_add_sub_digits: RTL and testbench
========================================

Name: serial_add_sub_digits

Overview:
- Parametrised successor to the bit-serial adder with valid/last framing.
- Adds or subtracts two unsigned/two's-complement numbers presented least-significant digit first, DIGIT_W bits per valid beat.
- A word is framed by vld/last. The operation is latched per word, and each result digit is registered.
- Final carry/borrow, signed overflow and a word-length error are reported with the last result digit.
- Sits between serial data sources and narrow serial datapaths that need add and subtract without a parallel adder.

Parameters:
- DIGIT_W, 4, bits consumed per valid beat (>=1).
- MAX_DIGITS, 16, maximum digits per word; longer words flag len_err.
- CNT_W, $clog2(MAX_DIGITS+1), width of the digit counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- vld  in  1  a, b, last, sub are valid this cycle
- a  in  DIGIT_W  operand A digit, LS digit first
- b  in  DIGIT_W  operand B digit
- last  in  1  this digit is the word's MS digit (honoured only with vld)
- sub  in  1  1 = A-B, 0 = A+B; sampled only on the first digit of a word
- sum_vld  out  1  sum digit valid
- sum  out  DIGIT_W  result digit
- sum_last  out  1  marks the MS result digit
- carry_out  out  1  final carry (add) / no-borrow (sub); valid with sum_last
- overflow  out  1  signed overflow of the whole word; valid with sum_last
- len_err  out  1  word exceeded MAX_DIGITS; valid with sum_last
- digit_cnt  out  CNT_W  digits accepted so far in the current word (saturating)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, carry=0, op=ADD, digit_cnt=0, err flag=0.
  - All outputs go to 0 immediately and stay 0 while rst is high.
- FSM states:
  - IDLE: no word in progress.
  - BUSY: at least one digit of a word accepted, last not yet seen.
- IDLE, vld=1:
  - Latch op=sub.
  - Compute with cin = sub (0 for add, 1 for sub), using b_eff = sub ? ~b : b.
  - If last=0, go to BUSY. If last=1, it is a single-digit word and the FSM stays in IDLE.
- BUSY, vld=1: compute with cin=carry and the latched op. The sub input is ignored.
- vld=0 in any state:
  - No state change; carry and op held (gaps allowed mid-word).
  - sum_vld=0 next cycle. sum, sum_last and flags hold their previous values.
- Digit arithmetic: {cout, sum_d} = a + b_eff + cin, at DIGIT_W+1 bits. cmsb = carry into bit DIGIT_W-1.
- Latency: 1 cycle. Inputs accepted at edge N appear on sum/sum_vld after edge N, i.e. valid in cycle N+1.
- Each valid non-last beat: carry<=cout, digit_cnt<=sat(digit_cnt+1), sum_last=0.
- vld && last:
  - sum_last=1, carry_out=cout, overflow=cout^cmsb.
  - len_err = err flag | (digit_cnt+1 > MAX_DIGITS).
  - Next state IDLE; carry, op, digit_cnt and err flag are cleared in the same edge.
  - The next beat starts a fresh word.
- last without vld: ignored, no state effect.
- digit_cnt saturates at MAX_DIGITS. Exceeding it sets the internal err flag, which is sticky until the word's last beat. Arithmetic continues unaffected.
- carry_out, overflow and len_err are 0 on non-last result beats.
- Reset mid-word: the word is discarded and no sum_last is produced. The first vld after release starts a new word.
- No backpressure: the block always accepts.

Decomposition:
- Package serial_arith_pkg holds:
  - op_t enum {OP_ADD, OP_SUB}
  - state_t enum {ST_IDLE, ST_BUSY}
  - DIGIT_W_DEFAULT and MAX_DIGITS_DEFAULT constants.
- One combinational sub-module, digit_adder #(DIGIT_W):
  - Inputs a, b, cin, inv_b.
  - Outputs sum, cout, cmsb.
  - Instantiated once. FSM, counter and output registers stay in the top.

Test Plan:
- Add, DIGIT_W=4: a digits 4,3,2,1 with b digits F,F,F,0, sub=0, last on 4th beat -> sum 3,3,2,2 (0x2233); carry_out=0; overflow=0; sum_last on 4th result only.
- Subtract: a digits 5,0 with b digits 7,0, sub=1 on beat 1 (sub toggled to 0 on beat 2) -> sum E,F (0xFE); carry_out=0 (borrow); overflow=0; op held despite toggle.
- Signed overflow: a digits F,7 with b digits 1,0, add -> sum 0,8 (0x80); carry_out=0; overflow=1.
- Gaps and ignored last: vld low for 3 cycles between digits with last=1 during the gap -> result identical to the gapless run; no sum_last during the gap; sum_vld=0 in gap cycles.
- Reset mid-word: 2 of 4 digits sent, rst pulsed -> outputs 0 at once, no sum_last. Next word 0x0001+0x0001 (digits 1,0 + 1,0) -> sum 2,0; carry starts at 0.
- Length error, MAX_DIGITS=4: 6-digit word -> digit_cnt saturates at 4; len_err=1 with sum_last; next 2-digit word -> len_err=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and default sizing for the digit-serial add/subtract block.
//   op_t    : operation latched at the first digit of a word
//   state_t : word framing state (idle / word in progress)
package serial_arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int DIGIT_W_DEFAULT    = 4;
    localparam int MAX_DIGITS_DEFAULT = 16;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT_W-bit adder slice with optional operand inversion.
//   a, b   : operand digits
//   cin    : carry in (1 on the first digit of a subtract)
//   inv_b  : 1 = use ~b (subtract), 0 = use b
//   sum    : result digit
//   cout   : carry out of the MS bit
//   cmsb   : carry into the MS bit (used for signed overflow)
module digit_adder #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    input  logic               inv_b,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               cmsb
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   full;

    assign b_eff = inv_b ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    assign sum   = full[DIGIT_W-1:0];
    assign cout  = full[DIGIT_W];
    // A sum bit is a ^ b ^ carry_in, so the carry into the MS bit falls out
    // of the MS bits without building a separate ripple chain.
    assign cmsb  = full[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];

endmodule

// File: rtl/serial_add_sub_digits.sv
// Digit-serial adder/subtractor, LS digit first, vld/last framed words.
//   clk, rst         : clock, asynchronous active-high reset
//   vld, a, b        : input digit beat
//   last             : beat carries the word's MS digit
//   sub              : operation, sampled on the first digit of a word only
//   sum_vld, sum     : registered result digit (1 cycle latency)
//   sum_last         : result digit is the word's MS digit
//   carry_out        : final carry (add) / no-borrow (sub), with sum_last
//   overflow         : signed overflow of the word, with sum_last
//   len_err          : word longer than MAX_DIGITS, with sum_last
//   digit_cnt        : digits accepted so far in the current word (saturating)
module serial_add_sub_digits
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W    = DIGIT_W_DEFAULT,
    parameter int MAX_DIGITS = MAX_DIGITS_DEFAULT,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               last,
    input  logic               sub,
    output logic               sum_vld,
    output logic [DIGIT_W-1:0] sum,
    output logic               sum_last,
    output logic               carry_out,
    output logic               overflow,
    output logic               len_err,
    output logic [CNT_W-1:0]   digit_cnt
);

    localparam logic [CNT_W:0] MAX_EXT = (CNT_W + 1)'(MAX_DIGITS);

    state_t state_reg, state_next;
    op_t    op_reg, op_next, op_eff;
    logic   carry_reg, carry_next;
    logic   err_reg, err_next;
    logic   cin_eff;

    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W:0]     cnt_inc;
    logic               cnt_over;

    logic               sum_vld_next, sum_last_next;
    logic [DIGIT_W-1:0] sum_next;
    logic               carry_out_next, overflow_next, len_err_next;

    logic [DIGIT_W-1:0] add_sum;
    logic               add_cout, add_cmsb;

    // The first digit of a word takes its operation straight from sub; later
    // digits reuse the latched op so sub may change mid-word.
    assign op_eff  = (state_reg == ST_IDLE) ? (sub ? OP_SUB : OP_ADD) : op_reg;
    assign cin_eff = (state_reg == ST_IDLE) ? (op_eff == OP_SUB) : carry_reg;

    assign cnt_inc  = {1'b0, digit_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_over = (cnt_inc > MAX_EXT);

    digit_adder #(
        .DIGIT_W (DIGIT_W)
    ) u_digit_adder (
        .a     (a),
        .b     (b),
        .cin   (cin_eff),
        .inv_b (op_eff == OP_SUB),
        .sum   (add_sum),
        .cout  (add_cout),
        .cmsb  (add_cmsb)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: last is only meaningful together with vld
    always_comb begin
        state_next = state_reg;
        if (vld) begin
            state_next = last ? ST_IDLE : ST_BUSY;
        end
    end

    // Datapath / output next-values
    always_comb begin
        carry_next     = carry_reg;
        op_next        = op_reg;
        cnt_next       = digit_cnt;
        err_next       = err_reg;
        sum_vld_next   = vld;
        sum_next       = sum;
        sum_last_next  = sum_last;
        carry_out_next = carry_out;
        overflow_next  = overflow;
        len_err_next   = len_err;
        if (vld) begin
            sum_next = add_sum;
            if (last) begin
                sum_last_next  = 1'b1;
                carry_out_next = add_cout;
                overflow_next  = add_cout ^ add_cmsb;
                len_err_next   = err_reg | cnt_over;
                // Word complete: clear per-word context for the next word
                carry_next     = 1'b0;
                op_next        = OP_ADD;
                cnt_next       = '0;
                err_next       = 1'b0;
            end else begin
                sum_last_next  = 1'b0;
                carry_out_next = 1'b0;
                overflow_next  = 1'b0;
                len_err_next   = 1'b0;
                carry_next     = add_cout;
                op_next        = op_eff;
                // Counter saturates; the overrun is remembered in err_reg
                if (cnt_over) begin
                    err_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_reg <= 1'b0;
            op_reg    <= OP_ADD;
            err_reg   <= 1'b0;
            digit_cnt <= '0;
            sum_vld   <= 1'b0;
            sum       <= '0;
            sum_last  <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            carry_reg <= carry_next;
            op_reg    <= op_next;
            err_reg   <= err_next;
            digit_cnt <= cnt_next;
            sum_vld   <= sum_vld_next;
            sum       <= sum_next;
            sum_last  <= sum_last_next;
            carry_out <= carry_out_next;
            overflow  <= overflow_next;
            len_err   <= len_err_next;
        end
    end

endmodule

// File: tb/tb_serial_add_sub_digits.sv
// Scoreboard bench for serial_add_sub_digits (DIGIT_W=4, MAX_DIGITS=4).
// Expected result beats are computed per word with whole-word integer
// arithmetic and queued; a negedge monitor pops one entry per sum_vld.
module tb_serial_add_sub_digits;

    localparam int DW   = 4;
    localparam int MAXD = 4;
    localparam int CW   = $clog2(MAXD + 1);

    logic          clk = 1'b0;
    logic          rst, vld, last, sub;
    logic [DW-1:0] a, b;
    logic          sum_vld, sum_last, carry_out, overflow, len_err;
    logic [DW-1:0] sum;
    logic [CW-1:0] digit_cnt;

    serial_add_sub_digits #(
        .DIGIT_W    (DW),
        .MAX_DIGITS (MAXD),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .a         (a),
        .b         (b),
        .last      (last),
        .sub       (sub),
        .sum_vld   (sum_vld),
        .sum       (sum),
        .sum_last  (sum_last),
        .carry_out (carry_out),
        .overflow  (overflow),
        .len_err   (len_err),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] sum;
        bit            last;
        bit            cout;
        bit            ovf;
        bit            lerr;
        int            cnt;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] wa[8];
    logic [DW-1:0] wb[8];
    bit            prev_gap = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: whole-word arithmetic on n-digit integers
    task automatic push_word(input int n, input bit s);
        longint A = 0, B = 0, R, mask, half, sa, sb, sr;
        bit     cout, ovf;
        int     w = DW * n;
        exp_t   e;
        for (int i = 0; i < n; i++) begin
            A = A | (longint'(wa[i]) << (DW * i));
            B = B | (longint'(wb[i]) << (DW * i));
        end
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa = (A >= half) ? A - (mask + 1) : A;
        sb = (B >= half) ? B - (mask + 1) : B;
        if (s) begin
            R    = (A - B) & mask;
            cout = (A >= B);
            sr   = sa - sb;
        end else begin
            R    = A + B;
            cout = ((R >> w) & 1) != 0;
            R    = R & mask;
            sr   = sa + sb;
        end
        ovf = (sr >= half) || (sr < -half);
        for (int i = 0; i < n; i++) begin
            e.sum  = DW'((R >> (DW * i)) & ((longint'(1) << DW) - 1));
            e.last = (i == n - 1);
            e.cout = e.last ? cout : 1'b0;
            e.ovf  = e.last ? ovf : 1'b0;
            e.lerr = e.last && (n > MAXD);
            e.cnt  = e.last ? 0 : ((i + 1 < MAXD) ? i + 1 : MAXD);
            q.push_back(e);
        end
    endtask

    task automatic set_digits(input logic [31:0] av, input logic [31:0] bv);
        for (int i = 0; i < 8; i++) begin
            wa[i] = av[DW*i +: DW];
            wb[i] = bv[DW*i +: DW];
        end
    endtask

    task automatic gap_check();
        if (prev_gap) begin
            check("gap_vld", sum_vld, 0);
            check("gap_last", sum_last, 0);
        end
    endtask

    // Drives one word; optional gap of gap_len idle cycles after digit gap_at
    task automatic drive_word(input int n, input bit s, input int gap_at, input int gap_len);
        push_word(n, s);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            gap_check();
            vld  = 1'b1;
            a    = wa[i];
            b    = wb[i];
            last = (i == n - 1);
            sub  = (i == 0) ? s : ~s;
            prev_gap = 1'b0;
            if (i == gap_at && i != n - 1) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    gap_check();
                    vld  = 1'b0;
                    last = 1'b1;
                    a    = DW'($urandom);
                    b    = DW'($urandom);
                    sub  = 1'($urandom);
                    prev_gap = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        vld = 1'b0; last = 1'b0;
        prev_gap = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vld"}, sum_vld, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_last"}, sum_last, 0);
        check({tag, "_cout"}, carry_out, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_lerr"}, len_err, 0);
        check({tag, "_cnt"}, digit_cnt, 0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && sum_vld) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_vld actual=1 required=0 (queue empty)");
            end else begin
                mon_e = q.pop_front();
                check("sum", sum, mon_e.sum);
                check("sum_last", sum_last, mon_e.last);
                check("carry_out", carry_out, mon_e.cout);
                check("overflow", overflow, mon_e.ovf);
                check("len_err", len_err, mon_e.lerr);
                check("digit_cnt", digit_cnt, mon_e.cnt);
            end
        end
    end

    initial begin
        exp_t e;
        int   n, ga;
        rst = 1'b1; vld = 1'b0; last = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Add: 0x1234 + 0x0FFF = 0x2233
        set_digits(32'h1234, 32'h0FFF);
        drive_word(4, 1'b0, -1, 0);
        // Subtract: 0x05 - 0x07 = 0xFE with borrow, sub toggled on beat 2
        set_digits(32'h05, 32'h07);
        drive_word(2, 1'b1, -1, 0);
        // Signed overflow: 0x7F + 0x01 = 0x80
        set_digits(32'h7F, 32'h01);
        drive_word(2, 1'b0, -1, 0);
        // Same add as the first word, with a 3-cycle gap and last=1 in the gap
        set_digits(32'h1234, 32'h0FFF);
        drive_word(4, 1'b0, 1, 3);

        // Reset mid-word: only the first digit's result survives
        e.sum = 4'hB; e.last = 0; e.cout = 0; e.ovf = 0; e.lerr = 0; e.cnt = 1;
        q.push_back(e);
        @(posedge clk); #1;
        vld = 1'b1; a = 4'h5; b = 4'h6; last = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 4'h3; b = 4'h4;
        @(posedge clk); #1;
        vld = 1'b0; a = '0; b = '0;
        check("pre_rst_vld", sum_vld, 1);
        check("pre_rst_cnt", digit_cnt, 2);
        #1 rst = 1'b1;
        #1 check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_digits(32'h01, 32'h01);
        drive_word(2, 1'b0, -1, 0);

        // Length error on a 6-digit word, then a clean 2-digit word
        set_digits($urandom, $urandom);
        drive_word(6, 1'b0, -1, 0);
        set_digits($urandom, $urandom);
        drive_word(2, 1'b1, -1, 0);

        // Random words
        for (int k = 0; k < 40; k++) begin
            n  = $urandom_range(1, 6);
            ga = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            set_digits($urandom, $urandom);
            drive_word(n, 1'($urandom), ga, $urandom_range(1, 3));
        end

        for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
